sram_bist_seq: RTL and testbench
================================

SRAM_BIST_SEQ -- requirements
Module: sram_bist_seq

Interface
REQ-001 SHALL have parameter AW, default 10, SRAM address width.
REQ-002 SHALL have parameter DW, default 12, SRAM data width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that launches a run from IDLE.
REQ-006 SHALL have port base_addr  input  AW  first address of the run.
REQ-007 SHALL have port stride  input  AW  address increment per entry.
REQ-008 SHALL have port base_data  input  DW  pattern value for the first entry.
REQ-009 SHALL have port step  input  DW  pattern increment per entry.
REQ-010 SHALL have port count  input  AW+1  number of entries, 0..2^AW.
REQ-011 SHALL have port address  output  AW  SRAM address.
REQ-012 SHALL have port we  output  1  SRAM write enable.
REQ-013 SHALL have port re  output  1  SRAM read enable.
REQ-014 SHALL have port wr_data  output  DW  data driven to SRAM; top level tristates it with we.
REQ-015 SHALL have port rd_data  input  DW  SRAM read data, valid the cycle after re.
REQ-016 SHALL have port busy  output  1  run in progress.
REQ-017 SHALL have port done  output  1  one-cycle pulse at run end.
REQ-018 SHALL have port pass  output  1  all compares matched; held until next start.

Function
REQ-019 SHALL capture base_addr, stride, base_data, step and count on the accepted start; later input changes SHALL NOT affect the run.
REQ-020 SHALL implement FSM IDLE -> WR -> RD -> CMP -> (WR | DONE) -> IDLE, one cycle per state.
REQ-021 In WR, SHALL assert we=1, re=0, with address = current address and wr_data = current pattern.
REQ-022 In RD, SHALL assert we=0, re=1, with the same address.
REQ-023 In CMP, SHALL hold we=re=0 and compare rd_data against the current pattern; a mismatch SHALL clear pass.
REQ-024 After CMP, SHALL set address = (address + stride) mod 2^AW and pattern = (pattern + step) mod 2^DW, decrement the remaining count, and go to WR if remaining is nonzero, otherwise to DONE.
REQ-025 Per-entry latency SHALL be 3 cycles; a run of N entries SHALL assert busy for 3N+1 cycles (WR of entry 0 through DONE).
REQ-026 In DONE, SHALL pulse done=1 for exactly one cycle, then return to IDLE with busy=0.
REQ-027 start with count=0 SHALL go directly to DONE with pass=1 and no SRAM access.
REQ-028 start while busy SHALL be ignored.
REQ-029 In IDLE and DONE, SHALL hold we=re=0.
REQ-030 pass SHALL be set to 1 on the accepted start.

Reset
REQ-031 On rst, SHALL enter IDLE with address=0, wr_data=0, we=0, re=0, busy=0, done=0, pass=0 and all counters=0; rst SHALL take priority over start.
REQ-032 rst mid-run SHALL abort on the next edge with no further SRAM access.

Configuration
REQ-033 Macro SRAM_BIST_ERRLOG_EN, when defined, SHALL add output err_count (AW+1 bits, saturating count of mismatches) and output first_fail_addr (AW bits, address of the first mismatch, 0 if none), both cleared on start and on rst.
REQ-034 Without SRAM_BIST_ERRLOG_EN, those ports and their logic SHALL be absent, and pass SHALL be the only result.

Structure
REQ-035 A shared package sram_pkg SHALL hold the AW and DW defaults and the FSM state typedef (IDLE, WR, RD, CMP, DONE).
REQ-036 A sub-module sram_bist_agen SHALL hold the address/pattern accumulators and the remaining-count logic; the FSM SHALL stay in sram_bist_seq.

Verification
REQ-037 Nominal run: base_addr=0, stride=12, base_data=0, step=99, count=11 against a behavioural SRAM -> writes 0@0, 99@12 … 990@120; pass=1; done at cycle 34 after start.
REQ-038 Fault run: SRAM model corrupts address 36 -> pass=0; with SRAM_BIST_ERRLOG_EN, err_count=1 and first_fail_addr=36.
REQ-039 Wrap run: base_addr=1020, stride=12, base_data=4090, step=10, count=3 -> addresses 1020, 8, 20 and data 4090, 4, 14; pass=1.
REQ-040 count=0 -> done pulses on the cycle after start, pass=1, and we/re never assert.
REQ-041 rst asserted in RD of entry 2 -> next cycle IDLE, we=re=busy=0; a new start of the same run then yields pass=1.
REQ-042 start pulsed again during a run -> ignored; the original count completes unchanged.

Source files
------------

// File: rtl/sram_pkg.sv
// sram_pkg: shared defaults and FSM state type for the SRAM BIST sequencer.
// Holds the default address/data widths and the sequencer state encoding.
package sram_pkg;

    localparam int AW_DEF = 10;
    localparam int DW_DEF = 12;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        CMP,
        DONE
    } state_t;

endpackage

// File: rtl/sram_bist_agen.sv
// sram_bist_agen: address/pattern accumulators and remaining-entry counter.
// Ports: clk, rst (sync, active-high); load captures base_addr/stride/
// base_data/step/count; adv steps to the next entry; addr/pattern are the
// current entry; last flags that the current entry is the final one.
module sram_bist_agen
    import sram_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          adv,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] stride,
    input  logic [DW-1:0] base_data,
    input  logic [DW-1:0] step,
    input  logic [AW:0]   count,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] pattern,
    output logic          last
);

    logic [AW-1:0] stride_q;
    logic [DW-1:0] step_q;
    logic [AW:0]   rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr     <= '0;
            pattern  <= '0;
            stride_q <= '0;
            step_q   <= '0;
            rem      <= '0;
        end else if (load) begin
            addr     <= base_addr;
            pattern  <= base_data;
            stride_q <= stride;
            step_q   <= step;
            rem      <= count;
        end else if (adv) begin
            addr     <= addr + stride_q;
            pattern  <= pattern + step_q;
            rem      <= rem - (AW+1)'(1);
        end
    end

    assign last = rem == (AW+1)'(1);

endmodule

// File: rtl/sram_bist_seq.sv
// sram_bist_seq: write/read/compare BIST sequencer for a single-port SRAM.
// Ports: clk, rst (sync, active-high), start pulse with run parameters
// base_addr/stride/base_data/step/count; SRAM side address/we/re/wr_data/
// rd_data (rd_data valid the cycle after re); status busy/done/pass.
// Optional macro SRAM_BIST_ERRLOG_EN adds err_count and first_fail_addr.
module sram_bist_seq
    import sram_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] stride,
    input  logic [DW-1:0] base_data,
    input  logic [DW-1:0] step,
    input  logic [AW:0]   count,
    output logic [AW-1:0] address,
    output logic          we,
    output logic          re,
    output logic [DW-1:0] wr_data,
    input  logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic          pass
`ifdef SRAM_BIST_ERRLOG_EN
    ,
    output logic [AW:0]   err_count,
    output logic [AW-1:0] first_fail_addr
`endif
);

    state_t state, state_nx;
    logic   load, adv, last, mismatch;

    sram_bist_agen #(.AW(AW), .DW(DW)) u_agen (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .adv       (adv),
        .base_addr (base_addr),
        .stride    (stride),
        .base_data (base_data),
        .step      (step),
        .count     (count),
        .addr      (address),
        .pattern   (wr_data),
        .last      (last)
    );

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nx;
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        adv      = 1'b0;
        we       = 1'b0;
        re       = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    load     = 1'b1;
                    state_nx = (count == '0) ? DONE : WR;
                end
            end
            WR: begin
                we       = 1'b1;
                state_nx = RD;
            end
            RD: begin
                re       = 1'b1;
                state_nx = CMP;
            end
            CMP: begin
                adv      = 1'b1;
                state_nx = last ? DONE : WR;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // wr_data still holds the current entry's pattern during CMP
    assign mismatch = (state == CMP) && (rd_data != wr_data);

    always_ff @(posedge clk) begin
        if (rst)
            pass <= 1'b0;
        else if (load)
            pass <= 1'b1;
        else if (mismatch)
            pass <= 1'b0;
    end

`ifdef SRAM_BIST_ERRLOG_EN
    always_ff @(posedge clk) begin
        if (rst || load) begin
            err_count       <= '0;
            first_fail_addr <= '0;
        end else if (mismatch) begin
            if (err_count == '0)
                first_fail_addr <= address;
            if (err_count != '1)
                err_count <= err_count + (AW+1)'(1);
        end
    end
`endif

endmodule

// File: tb/tb_sram_bist_seq.sv
// tb_sram_bist_seq: self-checking bench for sram_bist_seq with a behavioural SRAM.
module tb_sram_bist_seq;

    localparam int AW = 10;
    localparam int DW = 12;

    logic          clk = 0;
    logic          rst = 0;
    logic          start = 0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] stride = '0;
    logic [DW-1:0] base_data = '0;
    logic [DW-1:0] step = '0;
    logic [AW:0]   count = '0;
    logic [AW-1:0] address;
    logic          we, re, busy, done, pass;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
`ifdef SRAM_BIST_ERRLOG_EN
    logic [AW:0]   err_count;
    logic [AW-1:0] first_fail_addr;
`endif

    int checks = 0;
    int failures = 0;

    logic          fault_en = 0;
    logic [AW-1:0] fault_addr = '0;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    sram_bist_seq #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .stride    (stride),
        .base_data (base_data),
        .step      (step),
        .count     (count),
        .address   (address),
        .we        (we),
        .re        (re),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .pass      (pass)
`ifdef SRAM_BIST_ERRLOG_EN
        ,
        .err_count       (err_count),
        .first_fail_addr (first_fail_addr)
`endif
    );

    always #5 clk = ~clk;

    // behavioural SRAM: synchronous write, one-cycle read, optional stuck bit at fault_addr
    always @(posedge clk) begin
        if (we) mem[address] <= wr_data;
        if (re) rd_data <= mem[address] ^ ((fault_en && address == fault_addr) ? DW'(1) : DW'(0));
    end

    function automatic int hits(input logic [AW-1:0] ba, input logic [AW-1:0] st, input int n);
        int h = 0;
        for (int i = 0; i < n; i++)
            if (fault_en && AW'(ba + AW'(i) * st) == fault_addr) h++;
        return h;
    endfunction

    function automatic logic [AW-1:0] first_hit(input logic [AW-1:0] ba, input logic [AW-1:0] st, input int n);
        for (int i = 0; i < n; i++)
            if (fault_en && AW'(ba + AW'(i) * st) == fault_addr) return fault_addr;
        return '0;
    endfunction

    task automatic run(input logic [AW-1:0] ba, input logic [AW-1:0] st, input logic [DW-1:0] bd,
                       input logic [DW-1:0] sp, input logic [AW:0] cnt, input int restart_at,
                       output int done_cyc, output int busy_cyc, output int nwr, output int nrd,
                       output int bad_wr);
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        done_cyc = -1; busy_cyc = 0; nwr = 0; nrd = 0; bad_wr = 0;
        @(negedge clk);
        base_addr = ba; stride = st; base_data = bd; step = sp; count = cnt; start = 1;
        @(negedge clk);
        start = 0;
        base_addr = AW'($urandom); stride = AW'($urandom); base_data = DW'($urandom);
        step = DW'($urandom); count = (AW+1)'($urandom_range(1, 40));
        for (int c = 1; c <= 3 * int'(cnt) + 20; c++) begin
            if (we) begin
                ea = ba + AW'(nwr) * st;
                ed = bd + DW'(nwr) * sp;
                if (address !== ea || wr_data !== ed) bad_wr++;
                nwr++;
            end
            if (we && re) bad_wr++;
            if (re) nrd++;
            if (busy) busy_cyc++;
            if (done) begin
                done_cyc = c;
                break;
            end
            start = (c == restart_at);
            @(negedge clk);
        end
        start = 0;
        if (done_cyc < 0) begin
            checks++; failures++;
            $display("FAIL run_timeout: done not seen, required within %0d cycles", 3 * int'(cnt) + 20);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1; start = 1; count = 5;
        @(negedge clk);
        @(negedge clk);
        start = 0;
        checks++; if (address !== '0) begin failures++; $display("FAIL reset_address got=%0d exp=0", address); end
        checks++; if (wr_data !== '0) begin failures++; $display("FAIL reset_wr_data got=%0d exp=0", wr_data); end
        checks++; if ({we, re} !== 2'b00) begin failures++; $display("FAIL reset_we_re got=%b exp=00", {we, re}); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (pass !== 1'b0) begin failures++; $display("FAIL reset_pass got=%b exp=0", pass); end
`ifdef SRAM_BIST_ERRLOG_EN
        checks++; if (err_count !== '0 || first_fail_addr !== '0) begin failures++;
            $display("FAIL reset_errlog got=%0d/%0d exp=0/0", err_count, first_fail_addr); end
`endif
        rst = 0;
    endtask

    task automatic check_run(input string nm, input logic [AW-1:0] ba, input logic [AW-1:0] st,
                             input logic [DW-1:0] bd, input logic [DW-1:0] sp, input logic [AW:0] cnt,
                             input int restart_at);
        int dc, bc, nw, nr, bw, n, h;
        n = int'(cnt);
        h = hits(ba, st, n);
        run(ba, st, bd, sp, cnt, restart_at, dc, bc, nw, nr, bw);
        checks++; if (bw !== 0) begin failures++; $display("FAIL %s_writes bad=%0d exp=0", nm, bw); end
        checks++; if (nw !== n || nr !== n) begin failures++; $display("FAIL %s_access wr=%0d rd=%0d exp=%0d", nm, nw, nr, n); end
        checks++; if (dc !== 3 * n + 1) begin failures++; $display("FAIL %s_done_cycle got=%0d exp=%0d", nm, dc, 3 * n + 1); end
        checks++; if (bc !== 3 * n + 1) begin failures++; $display("FAIL %s_busy_cycles got=%0d exp=%0d", nm, bc, 3 * n + 1); end
        checks++; if (pass !== (h == 0)) begin failures++; $display("FAIL %s_pass got=%b exp=%b", nm, pass, h == 0); end
`ifdef SRAM_BIST_ERRLOG_EN
        checks++; if (err_count !== (AW+1)'(h) || first_fail_addr !== first_hit(ba, st, n)) begin failures++;
            $display("FAIL %s_errlog got=%0d/%0d exp=%0d/%0d", nm, err_count, first_fail_addr, h, first_hit(ba, st, n)); end
`endif
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++;
            $display("FAIL %s_idle_after busy=%b done=%b exp=0/0", nm, busy, done); end
    endtask

    task automatic test_nominal;
        fault_en = 0;
        check_run("nominal", 0, 12, 0, 99, 11, -1);
    endtask

    task automatic test_fault;
        fault_en = 1; fault_addr = 36;
        check_run("fault", 0, 12, 0, 99, 11, -1);
        checks++; if (pass !== 1'b0) begin failures++; $display("FAIL fault_pass_held got=%b exp=0", pass); end
        fault_en = 0;
    endtask

    task automatic test_wrap;
        fault_en = 0;
        check_run("wrap", 1020, 12, 4090, 10, 3, -1);
    endtask

    task automatic test_count0;
        fault_en = 0;
        check_run("count0", 5, 3, 7, 1, 0, -1);
    endtask

    task automatic test_start_busy;
        fault_en = 0;
        check_run("start_busy", 100, 7, 55, 3, 9, 10);
    endtask

    task automatic test_rst_mid;
        fault_en = 0;
        @(negedge clk);
        base_addr = 0; stride = 12; base_data = 0; step = 99; count = 11; start = 1;
        @(negedge clk);
        start = 0;
        // cycles 1..8: entry 2 is in RD at cycle 8
        for (int c = 1; c < 8; c++) @(negedge clk);
        checks++; if (re !== 1'b1 || address !== 10'd24) begin failures++;
            $display("FAIL rst_mid_rd re=%b addr=%0d exp=1/24", re, address); end
        rst = 1;
        @(negedge clk);
        checks++; if ({we, re, busy, done} !== 4'b0000) begin failures++;
            $display("FAIL rst_mid_abort we/re/busy/done=%b exp=0000", {we, re, busy, done}); end
        rst = 0;
        check_run("rst_rerun", 0, 12, 0, 99, 11, -1);
    endtask

    task automatic test_random;
        logic [AW-1:0] ba, st;
        logic [AW:0]   cnt;
        for (int i = 0; i < 8; i++) begin
            ba = AW'($urandom); st = AW'($urandom);
            cnt = (AW+1)'($urandom_range(0, 30));
            fault_en = 1'($urandom);
            fault_addr = ($urandom_range(0, 1) == 1 && cnt != 0) ? AW'(ba + AW'($urandom_range(0, int'(cnt) - 1)) * st)
                                                                 : AW'($urandom);
            check_run($sformatf("random%0d", i), ba, st, DW'($urandom), DW'($urandom), cnt,
                      ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3 * int'(cnt) + 1)) : -1);
        end
        fault_en = 0;
    endtask

    initial begin
        test_reset;
        test_nominal;
        test_fault;
        test_wrap;
        test_count0;
        test_rst_mid;
        test_start_busy;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
